// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter
// Collects one-cycle golden-nonce strobes from NUM_CORES hashcores and queues
// them, tagged with the core index, into a small FIFO for a serial consumer.
// Each core has a holding register so that strobes never have to wait for the
// FIFO. Holding registers drain into the FIFO one per cycle, picked
// round-robin. A core that strobes again before its previous result is taken
// overwrites that result and raises a sticky overrun flag.
//
// Optional build macro:
//   GN_DEDUP_EN - drop a granted result whose nonce equals the last nonce
//                 pushed from the same core.

module golden_nonce_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      hash_clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      gn_match,
    input  logic [32*NUM_CORES-1:0]   gn_nonce,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_nonce,
    output logic [2:0]                out_core,
    output logic [4:0]                fifo_count,
    output logic [NUM_CORES-1:0]      overrun,
    input  logic                      clr_overrun
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
    localparam logic [2:0] LAST_C  = 3'(NUM_CORES - 1);

    // Per-core holding registers
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [31:0]          hold_q [NUM_CORES];
    logic [31:0]          hold_d [NUM_CORES];
    logic [NUM_CORES-1:0] overrun_q, overrun_d;
    logic [NUM_CORES-1:0] ovr_set;

    // Round-robin start index: the core after the last one granted
    logic [2:0]           rr_q, rr_d;

    // Grant of this cycle
    logic                 gnt_vld;
    logic [2:0]           gnt_idx;
    logic [31:0]          gnt_nonce;
    logic [NUM_CORES-1:0] gnt_oh;
    logic                 push;

    // Result FIFO; each entry is {core index, nonce}
    logic [34:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [4:0]           count_q, count_d;
    logic                 fifo_full;
    logic                 pop;
    logic [34:0]          head;

`ifdef GN_DEDUP_EN
    logic [31:0]          last_q [NUM_CORES];
    logic [31:0]          last_d [NUM_CORES];
    logic [31:0]          gnt_last;
`endif

    assign fifo_full = (count_q == DEPTH_C);
    assign pop       = (count_q != 5'd0) && out_ready;

    // Round-robin pick: search from rr_q upward first, then wrap to core 0.
    // Fullness is judged on the registered count, so a pop in the same cycle
    // does not open a slot for a grant.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_nonce = '0;
        gnt_oh    = '0;
`ifdef GN_DEDUP_EN
        gnt_last  = '1;
`endif
        if (!fifo_full) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!gnt_vld && pend_q[j] && (j >= int'(rr_q))) begin
                    gnt_vld   = 1'b1;
                    gnt_idx   = 3'(j);
                    gnt_nonce = hold_q[j];
                    gnt_oh[j] = 1'b1;
`ifdef GN_DEDUP_EN
                    gnt_last  = last_q[j];
`endif
                end
            end
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!gnt_vld && pend_q[j] && (j < int'(rr_q))) begin
                    gnt_vld   = 1'b1;
                    gnt_idx   = 3'(j);
                    gnt_nonce = hold_q[j];
                    gnt_oh[j] = 1'b1;
`ifdef GN_DEDUP_EN
                    gnt_last  = last_q[j];
`endif
                end
            end
        end
    end

    // Advance the round-robin pointer past the granted core
    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == LAST_C) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

`ifdef GN_DEDUP_EN
    // A grant that repeats the core's previous pushed nonce is consumed silently
    always_comb begin
        push   = gnt_vld && (gnt_nonce != gnt_last);
        last_d = last_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (push && gnt_oh[k]) begin
                last_d[k] = gnt_nonce;
            end
        end
    end
`else
    // Every grant goes into the FIFO
    always_comb begin
        push = gnt_vld;
    end
`endif

    // Holding register update: a new strobe always wins over the grant clear;
    // it only counts as an overrun when the old value is not leaving this edge.
    always_comb begin
        pend_d  = pend_q;
        hold_d  = hold_q;
        ovr_set = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (gn_match[k]) begin
                hold_d[k] = gn_nonce[32*k +: 32];
                pend_d[k] = 1'b1;
                if (pend_q[k] && !gnt_oh[k]) begin
                    ovr_set[k] = 1'b1;
                end
            end else if (gnt_oh[k]) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    // Sticky overrun flags; a coincident new event survives the clear
    always_comb begin
        overrun_d = (clr_overrun ? '0 : overrun_q) | ovr_set;
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            overrun_q <= '0;
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

`ifdef GN_DEDUP_EN
    // Last pushed nonce per core; all-ones means nothing pushed yet
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                last_q[k] <= '1;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                last_q[k] <= last_d[k];
            end
        end
    end
`endif

    // FIFO storage; contents need no reset since the output is gated by count
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {gnt_idx, gnt_nonce};
        end
    end

    // Head presentation, forced to zero whenever the FIFO is empty
    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_valid  = (count_q != 5'd0);
        out_nonce  = out_valid ? head[31:0]  : 32'd0;
        out_core   = out_valid ? head[34:32] : 3'd0;
        fifo_count = count_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed bench for golden_nonce_arbiter (defaults NUM_CORES=4, FIFO_DEPTH=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expectations follow GN_DEDUP_EN when it is defined for the build.

module tb_golden_nonce_arbiter;

    localparam int NC = 4;

    logic           hash_clk = 1'b0;
    logic           rst_n    = 1'b0;
    logic [NC-1:0]  gn_match = '0;
    logic [32*NC-1:0] gn_nonce = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [31:0]    out_nonce;
    logic [2:0]     out_core;
    logic [4:0]     fifo_count;
    logic [NC-1:0]  overrun;
    logic           clr_overrun = 1'b0;

    int checks = 0;
    int errors = 0;

    golden_nonce_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
        .hash_clk    (hash_clk),
        .rst_n       (rst_n),
        .gn_match    (gn_match),
        .gn_nonce    (gn_nonce),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_nonce   (out_nonce),
        .out_core    (out_core),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge hash_clk);
    endtask

    task automatic set_n(input int k, input logic [31:0] v);
        gn_nonce[32*k +: 32] = v;
    endtask

    task automatic do_reset();
        gn_match    = '0;
        gn_nonce    = '0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        rst_n       = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic chk_head(input string tag, input int core, input logic [31:0] nonce);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_core"},  32'(out_core),  32'(core));
        chk({tag, "_nonce"}, out_nonce,      nonce);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ex_core3 [6];
        logic [31:0] ex_nonce3 [6];
        int ex_core4 [5];
        logic [31:0] ex_nonce4 [5];
        logic [31:0] dedup_cnt;

        ex_core3  = '{0, 1, 2, 3, 0, 1};
        ex_nonce3 = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25};
        ex_core4  = '{0, 1, 2, 3, 1};
        ex_nonce4 = '{32'd30, 32'd31, 32'd32, 32'd33, 32'h6};

        // ---- reset state ----
        do_reset();
        chk("rst_valid",   32'(out_valid),  32'd0);
        chk("rst_count",   32'(fifo_count), 32'd0);
        chk("rst_nonce",   out_nonce,       32'd0);
        chk("rst_core",    32'(out_core),   32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);

        // ---- single strobe, core 2 ----
        out_ready = 1'b1;
        gn_match  = 4'b0100;
        set_n(2, 32'h00bd9207);
        step(1);
        gn_match = '0;
        chk("t1_valid_t0", 32'(out_valid), 32'd0);
        step(1);
        chk_head("t1_head", 2, 32'h00bd9207);
        chk("t1_count1", 32'(fifo_count), 32'd1);
        step(1);
        chk("t1_count0", 32'(fifo_count), 32'd0);
        chk("t1_valid0", 32'(out_valid),  32'd0);

        // ---- all four cores strobe together ----
        do_reset();
        out_ready = 1'b1;
        gn_match  = 4'b1111;
        for (int k = 0; k < NC; k++) set_n(k, 32'(10 + k));
        step(1);
        gn_match = '0;
        step(1);
        for (int i = 0; i < NC; i++) begin
            chk_head($sformatf("t2_h%0d", i), i, 32'(10 + i));
            chk($sformatf("t2_cnt%0d", i), 32'(fifo_count), 32'd1);
            step(1);
        end
        chk("t2_count0",  32'(fifo_count), 32'd0);
        chk("t2_overrun", 32'(overrun),    32'd0);

        // ---- saturation with out_ready low ----
        do_reset();
        gn_match = 4'b1111;
        for (int k = 0; k < NC; k++) set_n(k, 32'(20 + k));
        step(1);
        gn_match = '0;
        step(1);
        gn_match = 4'b0001;
        set_n(0, 32'd24);
        step(1);
        gn_match = 4'b0010;
        set_n(1, 32'd25);
        step(1);
        gn_match = '0;
        step(1);
        chk("t3_full", 32'(fifo_count), 32'd4);
        step(3);
        chk("t3_sat",     32'(fifo_count), 32'd4);
        chk("t3_overrun", 32'(overrun),    32'd0);
        chk_head("t3_hold", 0, 32'd20);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_head($sformatf("t3_h%0d", i), ex_core3[i], ex_nonce3[i]);
            step(1);
            if (i == 0) chk("t3_nogrant_full", 32'(fifo_count), 32'd3);
        end
        chk("t3_empty_cnt",   32'(fifo_count), 32'd0);
        chk("t3_empty_nonce", out_nonce,       32'd0);
        chk("t3_empty_core",  32'(out_core),   32'd0);

        // ---- overrun on core 1 while FIFO full ----
        do_reset();
        gn_match = 4'b1111;
        for (int k = 0; k < NC; k++) set_n(k, 32'(30 + k));
        step(1);
        gn_match = '0;
        step(4);
        chk("t4_full", 32'(fifo_count), 32'd4);
        gn_match = 4'b0010;
        set_n(1, 32'h5);
        step(1);
        chk("t4_no_ovr", 32'(overrun), 32'd0);
        set_n(1, 32'h6);
        clr_overrun = 1'b1;
        step(1);
        gn_match    = '0;
        clr_overrun = 1'b0;
        chk("t4_ovr_setwins", 32'(overrun), 32'b0010);
        step(1);
        chk("t4_ovr_sticky", 32'(overrun), 32'b0010);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_head($sformatf("t4_h%0d", i), ex_core4[i], ex_nonce4[i]);
            step(1);
        end
        chk("t4_drained", 32'(fifo_count), 32'd0);
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        chk("t4_ovr_clr", 32'(overrun), 32'd0);

        // ---- asynchronous reset with queued entries ----
        do_reset();
        gn_match = 4'b0111;
        for (int k = 0; k < 3; k++) set_n(k, 32'(40 + k));
        step(1);
        gn_match = '0;
        step(3);
        chk("t5_queued", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid),  32'd0);
        chk("t5_rst_count", 32'(fifo_count), 32'd0);
        chk("t5_rst_nonce", out_nonce,       32'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("t5_post_valid", 32'(out_valid),  32'd0);
        chk("t5_post_count", 32'(fifo_count), 32'd0);
        gn_match = 4'b1001;
        set_n(0, 32'd50);
        set_n(3, 32'd53);
        step(1);
        gn_match = '0;
        step(1);
        chk_head("t5_first", 0, 32'd50);

        // ---- repeated nonce from core 0 ----
        do_reset();
        gn_match = 4'b0001;
        set_n(0, 32'h77);
        step(1);
        gn_match = '0;
        step(1);
        chk("t6_first", 32'(fifo_count), 32'd1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t6_popped", 32'(fifo_count), 32'd0);
        gn_match = 4'b0001;
        set_n(0, 32'h77);
        step(1);
        gn_match = '0;
        step(2);
`ifdef GN_DEDUP_EN
        dedup_cnt = 32'd0;
`else
        dedup_cnt = 32'd1;
`endif
        chk("t6_second", 32'(fifo_count), dedup_cnt);
        chk("t6_overrun", 32'(overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
